// File: rtl/rv_multicycle_ctrl_if.sv
// rv_multicycle_ctrl_if: request/acknowledge handshake for the shared instruction/data memory port
interface rv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;
  modport master(output mem_req, mem_we, mem_addr_sel, input mem_ack);
  modport slave(input mem_req, mem_we, mem_addr_sel, output mem_ack);
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle RV32I datapath
module rv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ir,
  input  logic             branch_taken,
  rv_multicycle_ctrl_if.master mem,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             alu_out_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             trap,
  output logic             trap_cause,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  state_t st, st_nx;
  logic [7:0] tcnt;
  logic [6:0] opc;
  logic req, we, asel, retire, legal, timeout;
  logic is_load, is_store, is_jmp, is_alu;
  logic unused_ir;
  assign opc       = ir[6:0];
  assign unused_ir = ^ir[31:7];
  assign legal     = opc inside {OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_BRANCH,
                                 OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
  assign is_load   = opc == OPC_LOAD;
  assign is_store  = opc == OPC_STORE;
  assign is_jmp    = opc == OPC_JAL || opc == OPC_JALR;
  assign is_alu    = opc == OPC_OP || opc == OPC_OPIMM;
  // An ack landing on the limit cycle still counts as progress
  assign timeout   = (st == FETCH || st == MEM) && !mem.mem_ack && tcnt == 8'(MEM_TIMEOUT - 1);
  always_comb begin
    st_nx      = st;
    req        = 1'b0;
    we         = 1'b0;
    asel       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 1'b0;
    alu_op     = 2'd0;
    alu_out_we = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    retire     = 1'b0;
    case (st)
      FETCH: begin
        req   = 1'b1;
        ir_we = mem.mem_ack;
        st_nx = mem.mem_ack ? DECODE : timeout ? TRAP : FETCH;
      end
      DECODE: begin
        alu_a_sel  = 2'd1;
        alu_b_sel  = 1'b1;
        alu_out_we = 1'b1;
        st_nx      = legal ? EXEC : TRAP;
      end
      EXEC: begin
        if (opc == OPC_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
          retire = 1'b1;
          st_nx  = FETCH;
        end else begin
          // JAL leaves the DECODE-computed target in alu_out untouched
          alu_out_we = opc != OPC_JAL;
          alu_a_sel  = opc == OPC_LUI ? 2'd2 : opc == OPC_AUIPC ? 2'd1 : 2'd0;
          alu_b_sel  = opc != OPC_OP && opc != OPC_JAL;
          alu_op     = is_alu ? 2'd1 : 2'd0;
          st_nx      = (is_load || is_store) ? MEM : WB;
        end
      end
      MEM: begin
        req    = 1'b1;
        asel   = 1'b1;
        we     = is_store;
        pc_we  = is_store && mem.mem_ack;
        retire = is_store && mem.mem_ack;
        st_nx  = mem.mem_ack ? (is_store ? FETCH : WB) : timeout ? TRAP : MEM;
      end
      WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        wb_sel = is_load ? 2'd1 : is_jmp ? 2'd2 : 2'd0;
        pc_sel = is_jmp;
        st_nx  = FETCH;
      end
      TRAP:    st_nx = TRAP;
      default: st_nx = FETCH;
    endcase
    // An instruction caught by reset must not touch architectural state
    if (!rst_n) {req, we, ir_we, pc_we, alu_out_we, reg_we, retire} = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= FETCH;
      tcnt       <= '0;
      instret    <= '0;
      trap_cause <= 1'b0;
    end else begin
      st      <= st_nx;
      tcnt    <= (st_nx != st || !req || mem.mem_ack) ? '0 : tcnt + 8'd1;
      instret <= instret + CNT_W'(retire);
      if (st_nx == TRAP && st != TRAP) trap_cause <= timeout;
    end
  end
  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_sel = asel;
  assign state            = st;
  assign trap             = st == TRAP;
endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Main sequencer for the team's multicycle RV32I datapath: register file, ALU, immediate generator, a shared ALU-output register, and a single shared instruction/data memory port.
Walks every instruction through FETCH/DECODE/EXEC/MEM/WB, drives all datapath selects and write enables, and owns the memory request handshake, including a timeout.
Reports a sticky trap on an illegal opcode or a bus timeout, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before bus error (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; reset is synchronous and active-low
ir  in  32  instruction register contents (opcode = ir[6:0])
branch_taken  in  1  comparator result for ir[14:12] on rs1/rs2, valid in EXEC
mem_ack  in  1  memory completes current request this cycle (read data valid same cycle)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write request (store), qualified by mem_req
mem_addr_sel  out  1  0=PC, 1=alu_out register
ir_we  out  1  load ir from memory read data
pc_we  out  1  update PC
pc_sel  out  1  0=PC+4, 1=alu_out register
alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
alu_b_sel  out  1  0=rs2, 1=immediate
alu_op  out  2  0=ADD, 1=decode funct3/funct7, 2=reserved
alu_out_we  out  1  capture ALU result into alu_out register
reg_we  out  1  register-file write of rd
wb_sel  out  2  0=alu_out, 1=memory read data, 2=PC+4
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
trap  out  1  sticky: illegal opcode or bus timeout
trap_cause  out  1  0=illegal opcode, 1=bus timeout
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low at clk edge): state=FETCH, instret=0, trap=0, trap_cause=0, timeout counter=0.
- Outputs are combinational from state/ir/mem_ack. Every enable and mem_req defaults to 0; every select defaults to 0.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ack: ir_we=1, go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_a_sel=1, alu_b_sel=1, alu_op=ADD, alu_out_we=1 (PC+imm precomputed). Legal opcodes go to EXEC; any other opcode goes to TRAP with trap_cause=0.
- Legal opcodes: 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
- EXEC, per opcode. All of these except BRANCH assert alu_out_we=1.
  - OP: a=rs1, b=rs2, op=1.
  - OP-IMM: a=rs1, b=imm, op=1.
  - LOAD/STORE/JALR: a=rs1, b=imm, op=ADD.
  - LUI: a=zero, b=imm, op=ADD.
  - AUIPC: a=PC, b=imm, op=ADD.
  - JAL: no ALU work; alu_out keeps the DECODE target, alu_out_we=0.
  - BRANCH: pc_we=1, pc_sel=branch_taken, instret increments, next state FETCH.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - LOAD on mem_ack: go to WB.
  - STORE on mem_ack: pc_we=1, pc_sel=0, instret increments, next state FETCH.
- WB: reg_we=1, pc_we=1, instret increments, next state FETCH.
  - wb_sel=1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel=1 for JAL/JALR, 0 otherwise. The JALR bit-0 clear is done by the datapath.
- Latencies with zero-wait memory (ack in the first request cycle):
  - BRANCH: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- Timeout counter:
  - Clears on entry to any state and whenever mem_req=0.
  - Increments each mem_req cycle without mem_ack.
  - Reaching MEM_TIMEOUT without ack goes to TRAP with trap_cause=1.
  - mem_ack in the same cycle as the limit wins: normal progress, no trap.
- TRAP: all enables 0, mem_req=0, trap=1. The state is absorbing; only reset leaves it.
- instret wraps modulo 2^CNT_W. It increments exactly once per retired instruction, and never for a trapped instruction.
- Reset mid-operation (including with mem_req high in MEM): next cycle is FETCH with mem_req reasserted. The aborted instruction does not retire and no pc_we/reg_we is issued.

Test Plan:
- Reset with rst_n low for 2 cycles, then release → state=0, instret=0, trap=0, mem_req=1 in the first cycle after release.
- ADDI x1,x0,5 (0x00500093) with zero-wait ack → states 0,1,2,4; in WB reg_we=1, wb_sel=0, pc_we=1, pc_sel=0; instret=1 after 4 cycles.
- LW (0x0000A103), ack delayed 3 cycles in MEM → mem_req stays high 4 cycles with mem_addr_sel=1, mem_we=0; WB has wb_sel=1; total 8 cycles.
- BEQ (0x00000463) with branch_taken=1, then branch_taken=0 → in EXEC, pc_we=1 with pc_sel=1, then pc_sel=0; no reg_we; 3 cycles each; instret +2.
- Opcode 0x0000007F → TRAP after DECODE, trap=1, trap_cause=0, instret unchanged; mem_req stays 0 until rst_n low.
- FETCH with no ack, MEM_TIMEOUT=16 → TRAP with trap_cause=1 after 16 cycles; repeat with ack on cycle 16 → no trap, goes to DECODE.
